// File: rtl/vga_timing_gen_pkg.sv
// vga_pkg: shared timing-mode type, the stock 640x480 mode and frame-size helpers
package vga_pkg;
  typedef struct packed {
    logic [15:0] h_active, h_fp, h_sync, h_bp;
    logic [15:0] v_active, v_fp, v_sync, v_bp;
  } mode_t;
  localparam mode_t MODE_640x480 = '{
    h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96, h_bp: 16'd48,
    v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,  v_bp: 16'd33
  };
  function automatic int axis_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction
  function automatic int h_total(mode_t m);
    return axis_total(int'(m.h_active), int'(m.h_fp), int'(m.h_sync), int'(m.h_bp));
  endfunction
  function automatic int v_total(mode_t m);
    return axis_total(int'(m.v_active), int'(m.v_fp), int'(m.v_sync), int'(m.v_bp));
  endfunction
endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one raster axis; flags describe the position after this edge
module vga_axis_counter import vga_pkg::*; #(
  parameter int CNT_W  = 10,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  output logic [CNT_W-1:0] nxt,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_active
);
  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] S_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] S_HI = CNT_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [CNT_W-1:0] ACT  = CNT_W'(ACTIVE);
  logic [CNT_W-1:0] cnt;
  always_comb begin
    wrap      = adv && cnt == LAST;
    nxt       = wrap ? '0 : adv ? cnt + 1'b1 : cnt;
    in_sync   = nxt >= S_LO && nxt <= S_HI;
    in_active = nxt < ACT;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= nxt;
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing with pixel divider, enable and strobes
module vga_timing_gen import vga_pkg::*; #(
  parameter int CLK_DIV   = 4,
  parameter int CNT_W     = 10,
  parameter int H_ACTIVE  = int'(MODE_640x480.h_active),
  parameter int H_FP      = int'(MODE_640x480.h_fp),
  parameter int H_SYNC    = int'(MODE_640x480.h_sync),
  parameter int H_BP      = int'(MODE_640x480.h_bp),
  parameter int V_ACTIVE  = int'(MODE_640x480.v_active),
  parameter int V_FP      = int'(MODE_640x480.v_fp),
  parameter int V_SYNC    = int'(MODE_640x480.v_sync),
  parameter int V_BP      = int'(MODE_640x480.v_bp),
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0
) (
  input  logic             sys_clk_i,
  input  logic             reset_ni,
  input  logic             en_i,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic             pixel_tick_o,
  output logic             line_start_o,
  output logic             frame_start_o,
  output logic             vblank_start_o
);
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] V_BLANK = CNT_W'(V_ACTIVE);
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic tick, h_wrap, v_wrap, h_sync, v_sync, h_act, v_act;
  assign tick = en_i && div_cnt == DIV_LAST;
  always_ff @(posedge sys_clk_i or negedge reset_ni)
    if (!reset_ni) div_cnt <= '0;
    else if (en_i) div_cnt <= tick ? '0 : div_cnt + 1'b1;
  vga_axis_counter #(.CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)) u_h (
    .clk(sys_clk_i), .rst_n(reset_ni), .adv(tick),
    .nxt(h_nxt), .wrap(h_wrap), .in_sync(h_sync), .in_active(h_act)
  );
  vga_axis_counter #(.CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)) u_v (
    .clk(sys_clk_i), .rst_n(reset_ni), .adv(h_wrap),
    .nxt(v_nxt), .wrap(v_wrap), .in_sync(v_sync), .in_active(v_act)
  );
  // outputs load the post-edge position so every output agrees with x_o/y_o
  always_ff @(posedge sys_clk_i or negedge reset_ni)
    if (!reset_ni) begin
      x_o            <= '0;
      y_o            <= '0;
      hsync_o        <= ~HSYNC_POL;
      vsync_o        <= ~VSYNC_POL;
      video_on_o     <= 1'b0;
      pixel_tick_o   <= 1'b0;
      line_start_o   <= 1'b0;
      frame_start_o  <= 1'b0;
      vblank_start_o <= 1'b0;
    end else begin
      x_o            <= h_nxt;
      y_o            <= v_nxt;
      hsync_o        <= h_sync ? HSYNC_POL : ~HSYNC_POL;
      vsync_o        <= v_sync ? VSYNC_POL : ~VSYNC_POL;
      video_on_o     <= h_act && v_act;
      pixel_tick_o   <= tick;
      line_start_o   <= h_wrap;
      frame_start_o  <= h_wrap && v_wrap;
      vblank_start_o <= h_wrap && v_nxt == V_BLANK;
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of the default 640x480 mode and a tiny reparametrised mode
module tb_vga_timing_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst1_n = 1'b0, en1 = 1'b1, rst2_n = 1'b0, en2 = 1'b1;
  logic [9:0] x1, y1, x2, y2;
  logic hs1, vs1, vo1, pt1, ls1, fs1, vb1;
  logic hs2, vs2, vo2, pt2, ls2, fs2, vb2;
  int n_chk = 0, n_fail = 0;

  vga_timing_gen dut1 (
    .sys_clk_i(clk), .reset_ni(rst1_n), .en_i(en1), .x_o(x1), .y_o(y1),
    .hsync_o(hs1), .vsync_o(vs1), .video_on_o(vo1), .pixel_tick_o(pt1),
    .line_start_o(ls1), .frame_start_o(fs1), .vblank_start_o(vb1)
  );
  vga_timing_gen #(
    .CLK_DIV(1), .HSYNC_POL(1'b1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut2 (
    .sys_clk_i(clk), .reset_ni(rst2_n), .en_i(en2), .x_o(x2), .y_o(y2),
    .hsync_o(hs2), .vsync_o(vs2), .video_on_o(vo2), .pixel_tick_o(pt2),
    .line_start_o(ls2), .frame_start_o(fs2), .vblank_start_o(vb2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int cyc, l1, l2, lx, ly, hmin, hmax, hlo, vmis, vsmis, bad, k, found;
    int f1, f2, fx, fy, fl, vbt, vbx, vby, vbl, smin, smax, vm2, pz;
    logic [9:0] hy;
    #12;
    chk("rst1_x", x1, 0);
    chk("rst1_y", y1, 0);
    chk("rst1_hsync", hs1, 1);
    chk("rst1_vsync", vs1, 1);
    chk("rst1_video", vo1, 0);
    chk("rst1_strobes", {pt1, ls1, fs1, vb1}, 0);
    chk("rst2_hsync", hs2, 0);
    chk("rst2_vsync", vs2, 1);
    @(negedge clk);
    rst1_n = 1'b1;
    @(negedge clk);
    chk("c1_tick", pt1, 0);
    chk("c1_x", x1, 0);
    chk("c1_video", vo1, 1);
    chk("c1_hsync", hs1, 1);
    chk("c1_vsync", vs1, 1);
    repeat (2) @(negedge clk);
    chk("c3_tick", pt1, 0);
    @(negedge clk);
    chk("c4_tick", pt1, 1);
    chk("c4_x", x1, 1);
    @(negedge clk);
    chk("c5_tick", pt1, 0);
    chk("c5_x", x1, 1);
    repeat (3) @(negedge clk);
    chk("c8_tick", pt1, 1);
    chk("c8_x", x1, 2);
    cyc = 8; l1 = -1; l2 = -1; lx = -1; ly = -1;
    hmin = 9999; hmax = -1; hlo = 0; vmis = 0; vsmis = 0;
    for (int i = 0; i < 7000; i++) begin
      @(negedge clk);
      cyc++;
      if (ls1) begin
        if (l1 < 0) begin l1 = cyc; lx = int'(x1); ly = int'(y1); end
        else if (l2 < 0) l2 = cyc;
      end
      if (hs1 == 1'b0) begin
        hlo++;
        if (int'(x1) < hmin) hmin = int'(x1);
        if (int'(x1) > hmax) hmax = int'(x1);
      end
      if (vo1 !== (x1 < 10'd640)) vmis++;
      if (vs1 !== 1'b1) vsmis++;
    end
    chk("line1_cycle", l1, 3200);
    chk("line_period", l2 - l1, 3200);
    chk("line1_x", lx, 0);
    chk("line1_y", ly, 1);
    chk("hsync_lo_min_x", hmin, 656);
    chk("hsync_lo_max_x", hmax, 751);
    chk("hsync_lo_cycles", hlo, 768);
    chk("video_on_mism", vmis, 0);
    chk("vsync_top_mism", vsmis, 0);
    found = 0;
    for (int i = 0; i < 4000 && found == 0; i++) begin
      @(negedge clk);
      if (pt1 && x1 == 10'd100) found = 1;
    end
    chk("reach_x100", found, 1);
    en1 = 1'b0;
    hy = y1;
    bad = 0;
    repeat (37) begin
      @(negedge clk);
      if (pt1 || ls1 || fs1 || vb1 || x1 !== 10'd100 || y1 !== hy || vo1 !== 1'b1 || hs1 !== 1'b1) bad++;
    end
    chk("en_hold_bad", bad, 0);
    en1 = 1'b1;
    k = 0; found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge clk);
      k++;
      if (pt1) found = 1;
    end
    chk("resume_wait", k, 4);
    chk("resume_x", x1, 101);
    #2 rst1_n = 1'b0;
    #1;
    chk("arst1_x", x1, 0);
    chk("arst1_y", y1, 0);
    chk("arst1_video", vo1, 0);
    @(negedge clk);
    rst1_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("restart1_x", x1, 1);
    chk("restart1_y", y1, 0);
    chk("restart1_tick", pt1, 1);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("m2_c1_tick", pt2, 1);
    chk("m2_c1_x", x2, 1);
    chk("m2_c1_y", y2, 0);
    chk("m2_c1_hsync", hs2, 0);
    cyc = 1; f1 = -1; f2 = -1; fx = -1; fy = -1; fl = -1;
    vbt = -1; vbx = -1; vby = -1; vbl = -1;
    hmin = 9999; hmax = -1; smin = 9999; smax = -1; vm2 = 0; pz = 0;
    for (int i = 0; i < 210; i++) begin
      @(negedge clk);
      cyc++;
      if (fs2) begin
        if (f1 < 0) begin f1 = cyc; fx = int'(x2); fy = int'(y2); fl = int'(ls2); end
        else if (f2 < 0) f2 = cyc;
      end
      if (vb2 && vbt < 0) begin vbt = cyc; vbx = int'(x2); vby = int'(y2); vbl = int'(ls2); end
      if (hs2 == 1'b1) begin
        if (int'(x2) < hmin) hmin = int'(x2);
        if (int'(x2) > hmax) hmax = int'(x2);
      end
      if (vs2 == 1'b0) begin
        if (int'(y2) < smin) smin = int'(y2);
        if (int'(y2) > smax) smax = int'(y2);
      end
      if (vo2 !== (x2 < 10'd8 && y2 < 10'd4)) vm2++;
      if (pt2 !== 1'b1) pz++;
    end
    chk("m2_frame1_cycle", f1, 98);
    chk("m2_frame_period", f2 - f1, 98);
    chk("m2_frame_x", fx, 0);
    chk("m2_frame_y", fy, 0);
    chk("m2_frame_line", fl, 1);
    chk("m2_vblank_cycle", vbt, 56);
    chk("m2_vblank_x", vbx, 0);
    chk("m2_vblank_y", vby, 4);
    chk("m2_vblank_line", vbl, 1);
    chk("m2_hsync_min_x", hmin, 10);
    chk("m2_hsync_max_x", hmax, 11);
    chk("m2_vsync_min_y", smin, 5);
    chk("m2_vsync_max_y", smax, 5);
    chk("m2_video_mism", vm2, 0);
    chk("m2_tick_gaps", pz, 0);
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      @(negedge clk);
      if (y2 == 10'd2 && x2 == 10'd5) found = 1;
    end
    chk("m2_reach_y2", found, 1);
    #2 rst2_n = 1'b0;
    #1;
    chk("arst2_x", x2, 0);
    chk("arst2_y", y2, 0);
    chk("arst2_hsync", hs2, 0);
    chk("arst2_vsync", vs2, 1);
    chk("arst2_video", vo2, 0);
    chk("arst2_tick", pt2, 0);
    @(negedge clk);
    rst2_n = 1'b1;
    @(negedge clk);
    chk("restart2_x", x2, 1);
    chk("restart2_y", y2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
